game_timer_bcd: RTL

Parametrised BCD game timer, successor to the fixed 3-digit seconds counter in the cartridge logic. Counts seconds up or down over a configurable number of BCD digits. Supports preset load, pause/resume and clear, and flags expiry at the terminal value. Sits between the game FSM (control strobes) and the seven-segment/HUD renderer (BCD digits).

---
 rtl/game_timer_bcd.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/game_timer_bcd.sv
// Purpose: BCD seconds game timer (up/down, preset load, pause/resume, clear, expiry flag).
// Latency: all outputs registered; controls act on the edge they are sampled; first step P edges after start.
// Backpressure: none; strobes are single-cycle controls, tick is a one-cycle pulse with no handshake.
//
// Ports:
//   sys_clk, sys_rst             clock, synchronous active-high reset
//   clear, load, load_bcd        clear to zero / preset (nibbles >9 clamp to 9)
//   dir, start, pause            direction (latched on accepted start), run, freeze
//   time_bcd, tenths_bcd         current time digits (digit 0 = units), tenths digit
//   tick, running, time_max_flag step pulse, RUN indicator, sticky terminal flag
// Optional feature: define GAME_TIMER_TENTHS_EN to count tenths of a second
// (prescaler period becomes CLK_FREQ_HZ/10); otherwise tenths_bcd stays 0.
module game_timer_bcd #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DIGITS      = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_bcd,
  input  logic                dir,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] time_bcd,
  output logic [3:0]          tenths_bcd,
  output logic                tick,
  output logic                running,
  output logic                time_max_flag
);

`ifdef GAME_TIMER_TENTHS_EN
  localparam int P = CLK_FREQ_HZ / 10;
`else
  localparam int P = CLK_FREQ_HZ;
`endif
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int W  = 4 * DIGITS;
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          dir_q;

  // One decimal step with ripple carry (up) or borrow (down).
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (!down) begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Terminal value: all nines counting up, all zeros counting down.
  function automatic logic is_terminal(input logic [W-1:0] v, input logic down);
    logic t;
    t = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != (down ? 4'd0 : 4'd9)) t = 1'b0;
    return t;
  endfunction

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  logic [W-1:0] next_time;
  logic         next_term;
  logic         sec_due;

  assign next_time = bcd_step(time_bcd, dir_q);
  assign next_term = is_terminal(next_time, dir_q);

`ifdef GAME_TIMER_TENTHS_EN
  // Seconds advance only when tenths wraps (9->0 up, 0->9 down).
  assign sec_due = (presc == P_LAST) && (tenths_bcd == (dir_q ? 4'd0 : 4'd9));
`else
  assign sec_due = (presc == P_LAST);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      state         <= IDLE;
      presc         <= '0;
      dir_q         <= 1'b0;
      time_bcd      <= '0;
      tenths_bcd    <= 4'd0;
      tick          <= 1'b0;
      running       <= 1'b0;
      time_max_flag <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load && state != RUN) begin
        state         <= IDLE;
        presc         <= '0;
        time_bcd      <= clamp_bcd(load_bcd);
        tenths_bcd    <= 4'd0;
        running       <= 1'b0;
        time_max_flag <= 1'b0;
      end else if (pause) begin
        // pause outranks start in every state; it only changes state in RUN
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (start && (state == IDLE || state == PAUSE)) begin
        dir_q <= dir;
        if (is_terminal(time_bcd, dir)) begin
          state         <= DONE;
          time_max_flag <= 1'b1;
          running       <= 1'b0;
          tenths_bcd    <= 4'd0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (state == RUN) begin
        if (presc == P_LAST) begin
          presc <= '0;
`ifdef GAME_TIMER_TENTHS_EN
          if (dir_q) tenths_bcd <= (tenths_bcd == 4'd0) ? 4'd9 : tenths_bcd - 4'd1;
          else       tenths_bcd <= (tenths_bcd == 4'd9) ? 4'd0 : tenths_bcd + 4'd1;
`endif
          if (sec_due) begin
            time_bcd <= next_time;
            tick     <= 1'b1;
            if (next_term) begin
              state         <= DONE;
              time_max_flag <= 1'b1;
              running       <= 1'b0;
              tenths_bcd    <= 4'd0;
            end
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule
